// File: rtl/dma_read_burst_master_if.sv
// Bus bundle for dma_read_burst_master: command strobe/status, Avalon-MM burst
// read master port and the streaming output port.
interface dma_read_burst_master_if #(
  parameter int DW = 32,
  parameter int AW = 32,
  parameter int LW = 16,
  parameter int BW = 5
);
  // Handshakes: a command is taken when avm_read=1 and avm_waitrequest=0, and
  // the master holds address/read/burstcount stable until then; read data has
  // no back-pressure and each avm_readdatavalid cycle carries one word; a
  // stream word moves when src_valid=1 and src_ready=1; start is only looked
  // at while busy=0.
  logic          start;
  logic [AW-1:0] start_addr;
  logic [LW-1:0] length;
  logic          busy;
  logic          done;

  logic [AW-1:0] avm_address;
  logic          avm_read;
  logic [BW-1:0] avm_burstcount;
  logic          avm_waitrequest;
  logic [DW-1:0] avm_readdata;
  logic          avm_readdatavalid;

  logic          src_valid;
  logic [DW-1:0] src_data;
  logic          src_ready;

  modport master (
    input  start, start_addr, length,
    input  avm_waitrequest, avm_readdata, avm_readdatavalid, src_ready,
    output busy, done, avm_address, avm_read, avm_burstcount,
    output src_valid, src_data
  );

  modport slave (
    output start, start_addr, length,
    output avm_waitrequest, avm_readdata, avm_readdatavalid, src_ready,
    input  busy, done, avm_address, avm_read, avm_burstcount,
    input  src_valid, src_data
  );
endinterface

// File: rtl/dma_read_burst_master.sv
// Avalon-MM burst read DMA master feeding a FIFO-buffered stream output.
// Optional DMA_RD_BURST_ALIGN_EN keeps bursts inside MAXB-word address blocks.
module dma_read_burst_master #(
  parameter int DW = 32,
  parameter int AW = 32,
  parameter int LW = 16,
  parameter int BW = 5,
  parameter int FW = 6
) (
  input  logic                   clk,
  input  logic                   rst_n,
  dma_read_burst_master_if.master bus,
  output logic [1:0]             dbg_state
);
  localparam int MAXB  = 2 ** (BW - 1);
  localparam int BPW   = DW / 8;
  localparam int BSH   = $clog2(BPW);
  localparam int DEPTH = 2 ** FW;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t        state, state_next;
  logic [AW-1:0] addr_q;
  logic [LW-1:0] remain_q;
  logic [FW:0]   outst_q, outst_next;
  logic [FW:0]   wptr_q, rptr_q;
  logic [FW:0]   level, level_next;
  logic          done_q, done_next;
  logic [DW-1:0] mem [DEPTH];

  logic [LW-1:0] cap;
  logic [BW-1:0] burst;
  logic [FW+1:0] credit_used;
  logic          issue_ok, accept, last_cmd, push, pop;

  always_comb begin
    cap = LW'(MAXB);
`ifdef DMA_RD_BURST_ALIGN_EN
    cap = LW'(MAXB) - LW'(addr_q[BSH +: BW-1]);
`endif
    if (remain_q < cap) burst = BW'(remain_q);
    else                burst = BW'(cap);
  end

  // Credit covers words already buffered plus words still in flight, so the
  // buffer can never overflow and read data never needs back-pressure.
  assign level       = wptr_q - rptr_q;
  assign credit_used = (FW+2)'(level) + (FW+2)'(outst_q) + (FW+2)'(burst);
  assign issue_ok    = credit_used <= (FW+2)'(DEPTH);

  assign bus.avm_read       = (state == ISSUE) && (remain_q != '0) && issue_ok;
  assign bus.avm_address    = addr_q;
  assign bus.avm_burstcount = burst;

  assign accept   = bus.avm_read && !bus.avm_waitrequest;
  assign last_cmd = accept && (remain_q == LW'(burst));
  assign push     = bus.avm_readdatavalid && (state != IDLE);
  assign pop      = bus.src_valid && bus.src_ready;

  assign outst_next = outst_q + (accept ? (FW+1)'(burst) : '0) - (FW+1)'(push);
  assign level_next = level + (FW+1)'(push) - (FW+1)'(pop);

  always_comb begin
    state_next = state;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (bus.length != '0) state_next = ISSUE;
          else                  done_next  = 1'b1;
        end
      end
      ISSUE: begin
        if (last_cmd) state_next = DRAIN;
      end
      DRAIN: begin
        if (outst_next == '0 && level_next == '0) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      done_q   <= 1'b0;
      addr_q   <= '0;
      remain_q <= '0;
      outst_q  <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
    end else begin
      state   <= state_next;
      done_q  <= done_next;
      outst_q <= outst_next;
      if (state == IDLE) begin
        if (bus.start) begin
          addr_q   <= bus.start_addr;
          remain_q <= bus.length;
        end
      end else if (accept) begin
        addr_q   <= addr_q + (AW'(burst) << BSH);
        remain_q <= remain_q - LW'(burst);
      end
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr_q[FW-1:0]] <= bus.avm_readdata;
  end

  assign bus.src_valid = (wptr_q != rptr_q);
  assign bus.src_data  = mem[rptr_q[FW-1:0]];
  assign bus.busy      = (state != IDLE);
  assign bus.done      = done_q;
  assign dbg_state     = state;
endmodule

// File: tb/tb_dma_read_burst_master.sv
// Self-checking bench for dma_read_burst_master: Avalon slave model, stream
// sink and scoreboards for command sequence and delivered data.
module tb_dma_read_burst_master;
  localparam int DW = 32, AW = 32, LW = 16, BW = 5, FW = 6;
  localparam int MAXB = 2 ** (BW - 1);
  localparam int BPW  = DW / 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  dma_read_burst_master_if #(.DW(DW), .AW(AW), .LW(LW), .BW(BW)) bus ();

  dma_read_burst_master #(.DW(DW), .AW(AW), .LW(LW), .BW(BW), .FW(FW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.master),
    .dbg_state (dbg_state)
  );

  int n_checks = 0, n_pass = 0;
  logic [DW-1:0] exp_q[$];
  logic [AW-1:0] exp_addr_q[$];
  logic [BW-1:0] exp_len_q[$];
  logic [DW-1:0] resp_q[$];
  int stall_left = 0, ready_mode = 0, gap_mode = 0;
  int accepted_words = 0, read_cycles = 0, done_cnt = 0;
  bit check_done_next = 1'b0;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Reference burst split: MAXB cap, remaining words, optional block boundary.
  task automatic push_cmds(input logic [AW-1:0] a, input int n);
    int rem;
    int b;
    logic [AW-1:0] cur;
    rem = n;
    cur = a;
    while (rem > 0) begin
      b = (rem < MAXB) ? rem : MAXB;
`ifdef DMA_RD_BURST_ALIGN_EN
      if (MAXB - int'((cur / BPW) % MAXB) < b) b = MAXB - int'((cur / BPW) % MAXB);
`endif
      exp_addr_q.push_back(cur);
      exp_len_q.push_back(BW'(b));
      cur = cur + AW'(b * BPW);
      rem -= b;
    end
  endtask

  task automatic push_data(input logic [AW-1:0] a, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(mem_word(a + AW'(i * BPW)));
  endtask

  // Avalon slave: optional waitrequest on the first command, one-cycle read latency.
  initial begin : slave
    logic [AW-1:0] hold_addr;
    logic [BW-1:0] hold_len;
    logic [AW-1:0] ea;
    logic [BW-1:0] el;
    bit stall_active;
    stall_active = 1'b0;
    hold_addr = '0;
    hold_len = '0;
    bus.avm_waitrequest = 1'b0;
    bus.avm_readdatavalid = 1'b0;
    bus.avm_readdata = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bus.avm_waitrequest = 1'b0;
        bus.avm_readdatavalid = 1'b0;
        stall_active = 1'b0;
      end else begin
        if (resp_q.size() > 0 && (gap_mode == 0 || $urandom_range(0, 3) != 0)) begin
          bus.avm_readdatavalid = 1'b1;
          bus.avm_readdata = resp_q.pop_front();
        end else begin
          bus.avm_readdatavalid = 1'b0;
        end
        if (bus.avm_read) read_cycles++;
        if (stall_active) begin
          n_checks++;
          if (bus.avm_read !== 1'b1 || bus.avm_address !== hold_addr || bus.avm_burstcount !== hold_len)
            $display("FAIL cmd_hold: got read=%b addr=%h len=%0d want read=1 addr=%h len=%0d",
                     bus.avm_read, bus.avm_address, bus.avm_burstcount, hold_addr, hold_len);
          else n_pass++;
        end
        if (bus.avm_read && stall_left > 0) begin
          if (!stall_active) begin
            hold_addr = bus.avm_address;
            hold_len = bus.avm_burstcount;
            stall_active = 1'b1;
          end
          stall_left--;
          bus.avm_waitrequest = 1'b1;
        end else begin
          stall_active = 1'b0;
          bus.avm_waitrequest = 1'b0;
        end
        if (bus.avm_read && !bus.avm_waitrequest) begin
          n_checks++;
          if (exp_addr_q.size() == 0) begin
            $display("FAIL cmd_unexpected: got addr=%h len=%0d want no command",
                     bus.avm_address, bus.avm_burstcount);
          end else begin
            ea = exp_addr_q.pop_front();
            el = exp_len_q.pop_front();
            if (bus.avm_address !== ea || bus.avm_burstcount !== el)
              $display("FAIL cmd: got addr=%h len=%0d want addr=%h len=%0d",
                       bus.avm_address, bus.avm_burstcount, ea, el);
            else n_pass++;
          end
          for (int i = 0; i < int'(bus.avm_burstcount); i++)
            resp_q.push_back(mem_word(bus.avm_address + AW'(i * BPW)));
          accepted_words += int'(bus.avm_burstcount);
        end
      end
    end
  end

  // Stream sink and data scoreboard; also checks done lands right after the last pop.
  initial begin : sink
    logic [DW-1:0] e;
    bus.src_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (check_done_next) begin
        check_done_next = 1'b0;
        n_checks++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0)
          $display("FAIL done_timing: got done=%b busy=%b want done=1 busy=0", bus.done, bus.busy);
        else n_pass++;
      end
      if (bus.done === 1'b1) done_cnt++;
      if (!rst_n) bus.src_ready = 1'b0;
      else begin
        case (ready_mode)
          0:       bus.src_ready = 1'b1;
          1:       bus.src_ready = 1'b0;
          default: bus.src_ready = 1'($urandom_range(0, 1));
        endcase
      end
      if (rst_n && bus.src_valid && bus.src_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL data_unexpected: got %h want no word", bus.src_data);
        end else begin
          e = exp_q.pop_front();
          if (bus.src_data !== e) $display("FAIL data: got %h want %h", bus.src_data, e);
          else n_pass++;
          if (exp_q.size() == 0) check_done_next = 1'b1;
        end
      end
    end
  end

  task automatic run_transfer(input logic [AW-1:0] a, input int n, input int rmode, input int gmode,
                              input bit poke_busy, input bit explicit_cmds, input int hold);
    int base_done, base_acc, cyc;
    bit seen;
    if (!explicit_cmds) push_cmds(a, n);
    push_data(a, n);
    ready_mode = (hold > 0) ? 1 : rmode;
    gap_mode = gmode;
    base_done = done_cnt;
    base_acc = accepted_words;
    @(negedge clk);
    bus.start = 1'b1;
    bus.start_addr = a;
    bus.length = LW'(n);
    @(negedge clk);
    bus.start = 1'b0;
    n_checks++;
    if (bus.busy !== 1'b1) $display("FAIL busy_rise: got %b want 1", bus.busy);
    else n_pass++;
    if (hold > 0) begin
      repeat (hold) @(negedge clk);
      n_checks++;
      if (accepted_words - base_acc != (2 ** FW) || bus.src_valid !== 1'b1 || bus.avm_read !== 1'b0)
        $display("FAIL credit_stall: got words=%0d valid=%b read=%b want words=%0d valid=1 read=0",
                 accepted_words - base_acc, bus.src_valid, bus.avm_read, 2 ** FW);
      else n_pass++;
      ready_mode = rmode;
    end
    seen = 1'b0;
    cyc = 0;
    while (!seen && cyc < 5000) begin
      if (poke_busy && cyc == 10) begin
        bus.start = 1'b1;
        bus.start_addr = a + AW'('h1000);
        bus.length = LW'(5);
      end else bus.start = 1'b0;
      @(negedge clk);
      cyc++;
      if (bus.done === 1'b1) seen = 1'b1;
    end
    bus.start = 1'b0;
    n_checks++;
    if (!seen) $display("FAIL done_timeout: got no done in %0d cycles want done", cyc);
    else n_pass++;
    repeat (3) @(negedge clk);
    n_checks++;
    if (done_cnt - base_done != 1 || exp_q.size() != 0 || exp_addr_q.size() != 0 ||
        bus.busy !== 1'b0 || bus.src_valid !== 1'b0)
      $display("FAIL xfer_end: got dones=%0d words_left=%0d cmds_left=%0d busy=%b valid=%b want 1 0 0 0 0",
               done_cnt - base_done, exp_q.size(), exp_addr_q.size(), bus.busy, bus.src_valid);
    else n_pass++;
  endtask

  task automatic check_reset_outputs(input string tag);
    logic [AW+BW+5:0] obs;
    obs = {bus.busy, bus.done, bus.avm_read, bus.src_valid, bus.avm_burstcount, bus.avm_address, dbg_state};
    n_checks++;
    if (obs !== '0) $display("FAIL %s: got %h want 0", tag, obs);
    else n_pass++;
  endtask

  task automatic test_reset();
    bus.start = 1'b0;
    bus.start_addr = '0;
    bus.length = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_in");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("reset_out");
  endtask

  task automatic test_basic_bursts();
    exp_addr_q.push_back(32'h100); exp_len_q.push_back(BW'(16));
    exp_addr_q.push_back(32'h140); exp_len_q.push_back(BW'(16));
    exp_addr_q.push_back(32'h180); exp_len_q.push_back(BW'(8));
    run_transfer(32'h100, 40, 0, 0, 1'b0, 1'b1, 0);
  endtask

  task automatic test_zero_length();
    int base_rd, base_done;
    base_rd = read_cycles;
    base_done = done_cnt;
    @(negedge clk);
    bus.start = 1'b1;
    bus.start_addr = 32'h500;
    bus.length = '0;
    @(negedge clk);
    bus.start = 1'b0;
    n_checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0)
      $display("FAIL zero_len_done: got done=%b busy=%b want done=1 busy=0", bus.done, bus.busy);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (bus.done !== 1'b0) $display("FAIL zero_len_pulse: got done=%b want 0", bus.done);
    else n_pass++;
    repeat (3) @(negedge clk);
    n_checks++;
    if (read_cycles != base_rd || done_cnt - base_done != 1)
      $display("FAIL zero_len_quiet: got reads=%0d dones=%0d want 0 1", read_cycles - base_rd, done_cnt - base_done);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    run_transfer(32'h4000, 100, 0, 0, 1'b0, 1'b0, 300);
  endtask

  task automatic test_waitrequest();
    stall_left = 5;
    run_transfer(32'h2000, 24, 0, 0, 1'b0, 1'b0, 0);
    n_checks++;
    if (stall_left != 0) $display("FAIL stall_used: got %0d left want 0", stall_left);
    else n_pass++;
  endtask

  task automatic test_align();
`ifdef DMA_RD_BURST_ALIGN_EN
    exp_addr_q.push_back(32'h108); exp_len_q.push_back(BW'(14));
    exp_addr_q.push_back(32'h140); exp_len_q.push_back(BW'(6));
`else
    exp_addr_q.push_back(32'h108); exp_len_q.push_back(BW'(16));
    exp_addr_q.push_back(32'h148); exp_len_q.push_back(BW'(4));
`endif
    run_transfer(32'h108, 20, 0, 0, 1'b0, 1'b1, 0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 6; k++)
      run_transfer(AW'($urandom) & ~AW'(BPW - 1), $urandom_range(1, 70), 2, 1, 1'b0, 1'b0, 0);
    run_transfer(32'hFFFF_FFC0, 40, 0, 0, 1'b0, 1'b0, 0);
  endtask

  task automatic test_back_to_back();
    run_transfer(32'h3000, 60, 2, 0, 1'b1, 1'b0, 0);
    run_transfer(32'h3400, 17, 0, 1, 1'b0, 1'b0, 0);
  endtask

  task automatic test_mid_reset();
    int cyc;
    push_cmds(32'h8000, 100);
    push_data(32'h8000, 100);
    ready_mode = 2;
    gap_mode = 1;
    @(negedge clk);
    bus.start = 1'b1;
    bus.start_addr = 32'h8000;
    bus.length = LW'(100);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (30) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("mid_reset");
    exp_q.delete();
    exp_addr_q.delete();
    exp_len_q.delete();
    check_done_next = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    while (resp_q.size() > 0 && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (resp_q.size() != 0 || bus.src_valid !== 1'b0 || bus.busy !== 1'b0)
      $display("FAIL stale_discard: got pending=%0d valid=%b busy=%b want 0 0 0",
               resp_q.size(), bus.src_valid, bus.busy);
    else n_pass++;
    run_transfer(32'h9000, 50, 2, 1, 1'b0, 1'b0, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got simulation still running want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic_bursts();
    test_zero_length();
    test_backpressure();
    test_waitrequest();
    test_align();
    test_random();
    test_back_to_back();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
